// File: rtl/modexp_rr_scheduler.sv
// Round-robin front end for a single shared modular-exponentiation engine.
// Grants one requester at a time, launches the engine, and returns a tagged result.
module modexp_rr_scheduler #(
  parameter int WIDTH   = 512,
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_number,
  input  logic [NUM_REQ*WIDTH-1:0] req_exponent,
  input  logic [NUM_REQ*WIDTH-1:0] req_modulus,
  output logic [WIDTH-1:0]         eng_number,
  output logic [WIDTH-1:0]         eng_exponent,
  output logic [WIDTH-1:0]         eng_modulus,
  output logic                     eng_start,
  output logic                     eng_abort,
  input  logic [WIDTH-1:0]         eng_result,
  input  logic                     eng_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [15:0]              job_count
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int WDW = 20;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] eng_number_q, eng_number_d;
  logic [WIDTH-1:0] eng_exponent_q, eng_exponent_d;
  logic [WIDTH-1:0] eng_modulus_q, eng_modulus_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      job_count_q, job_count_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [WIDTH-1:0] sel_number, sel_exponent, sel_modulus;
  logic             timeout_hit;

  // Scan starting at rr_ptr so the most recently served requester goes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_number   = req_number[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_exponent = req_exponent[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_modulus  = req_modulus[int'(win_idx)*WIDTH +: WIDTH];
  assign timeout_hit  = (wd_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      wd_q           <= '0;
      id_q           <= '0;
      eng_number_q   <= '0;
      eng_exponent_q <= '0;
      eng_modulus_q  <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      job_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      wd_q           <= wd_d;
      id_q           <= id_d;
      eng_number_q   <= eng_number_d;
      eng_exponent_q <= eng_exponent_d;
      eng_modulus_q  <= eng_modulus_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      job_count_q    <= job_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    wd_d           = wd_q;
    id_d           = id_q;
    eng_number_d   = eng_number_q;
    eng_exponent_d = eng_exponent_q;
    eng_modulus_d  = eng_modulus_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    job_count_d    = job_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          eng_number_d   = sel_number;
          eng_exponent_d = sel_exponent;
          eng_modulus_d  = sel_modulus;
          id_d           = IDW'(win_idx);
          if (int'(win_idx) == NUM_REQ - 1) rr_ptr_d = '0;
          else                              rr_ptr_d = win_idx + PW'(1);
          // A zero modulus is answered with an error without touching the engine.
          if (sel_modulus == '0) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (eng_done) begin
          rsp_data_d = eng_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (job_count_q != 16'hFFFF) job_count_d = job_count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant is gated by aresetn so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  if (aresetn && win_found) req_ready[win_idx] = 1'b1;
      S_ISSUE: eng_start = 1'b1;
      S_WAIT:  eng_abort = !eng_done && timeout_hit;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign eng_number   = eng_number_q;
  assign eng_exponent = eng_exponent_q;
  assign eng_modulus  = eng_modulus_q;
  assign rsp_id       = id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign job_count    = job_count_q;

endmodule

// File: tb/tb_modexp_rr_scheduler.sv
// Directed bench for modexp_rr_scheduler; a second instance with a short
// watchdog shares the stimulus and is only observed by the timeout scenario.
module tb_modexp_rr_scheduler;

  localparam int W = 16;
  localparam int N = 4;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_number, req_exponent, req_modulus;
  logic [W-1:0]   eng_result;
  logic           eng_done, rsp_ready;

  logic [N-1:0] req_ready, req_ready_t;
  logic [W-1:0] eng_number, eng_exponent, eng_modulus;
  logic [W-1:0] eng_number_t, eng_exponent_t, eng_modulus_t;
  logic         eng_start, eng_abort, rsp_valid, rsp_err, busy;
  logic         eng_start_t, eng_abort_t, rsp_valid_t, rsp_err_t, busy_t;
  logic [1:0]   rsp_id, rsp_id_t;
  logic [W-1:0] rsp_data, rsp_data_t;
  logic [15:0]  job_count, job_count_t;

  int checks = 0;
  int passes = 0;

  always #5 aclk = ~aclk;

  modexp_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .IDW(2), .TIMEOUT(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_number(req_number), .req_exponent(req_exponent), .req_modulus(req_modulus),
    .eng_number(eng_number), .eng_exponent(eng_exponent), .eng_modulus(eng_modulus),
    .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_result(eng_result), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .job_count(job_count)
  );

  modexp_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .IDW(2), .TIMEOUT(8)) dut_to (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready_t),
    .req_number(req_number), .req_exponent(req_exponent), .req_modulus(req_modulus),
    .eng_number(eng_number_t), .eng_exponent(eng_exponent_t), .eng_modulus(eng_modulus_t),
    .eng_start(eng_start_t), .eng_abort(eng_abort_t),
    .eng_result(eng_result), .eng_done(eng_done),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_id(rsp_id_t),
    .rsp_data(rsp_data_t), .rsp_err(rsp_err_t), .busy(busy_t), .job_count(job_count_t)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] n, input logic [W-1:0] e,
                         input logic [W-1:0] m);
    req_number[idx*W +: W]   = n;
    req_exponent[idx*W +: W] = e;
    req_modulus[idx*W +: W]  = m;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    req_valid = '0; eng_done = 1'b0; eng_result = '0; rsp_ready = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; req_valid = '1; eng_done = 1'b1; eng_result = 16'h1234; rsp_ready = 1'b1;
    req_number = '1; req_exponent = '1; req_modulus = '1;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); else passes++;
    checks++; if ({eng_start, eng_abort, rsp_valid, rsp_err, busy} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 00000", {eng_start, eng_abort, rsp_valid, rsp_err, busy}); else passes++;
    checks++; if ({eng_number, eng_exponent, eng_modulus} !== 48'h0)
      $display("[TB] FAIL reset_eng_ops: got %h want 0", {eng_number, eng_exponent, eng_modulus}); else passes++;
    checks++; if ({rsp_id, rsp_data, job_count} !== 34'h0)
      $display("[TB] FAIL reset_rsp: got %h want 0", {rsp_id, rsp_data, job_count}); else passes++;
    req_valid = '0; eng_done = 1'b0; rsp_ready = 1'b0;
    aresetn = 1'b1;
  endtask

  task automatic test_single_request();
    int stray = 0;
    do_reset();
    rsp_ready = 1'b1;
    set_ops(2, 16'd4, 16'd13, 16'd497);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL single_grant: got %b want 0100", req_ready); else passes++;
    tick();
    req_valid = '0;
    #1;
    checks++; if (eng_start !== 1'b1) $display("[TB] FAIL single_start: got %b want 1", eng_start); else passes++;
    checks++; if ({eng_number, eng_exponent, eng_modulus} !== {16'd4, 16'd13, 16'd497})
      $display("[TB] FAIL single_ops: got %0d %0d %0d want 4 13 497", eng_number, eng_exponent, eng_modulus); else passes++;
    for (int i = 1; i < 20; i++) begin
      tick();
      stray += int'(eng_start) + int'(rsp_valid);
    end
    checks++; if (stray !== 0) $display("[TB] FAIL single_quiet_wait: got %0d stray pulses want 0", stray); else passes++;
    tick();
    eng_done = 1'b1; eng_result = 16'd445;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL single_early_rsp: got %b want 0", rsp_valid); else passes++;
    tick();
    eng_done = 1'b0; eng_result = '0;
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd2, 16'd445, 1'b0})
      $display("[TB] FAIL single_rsp: got v=%b id=%0d data=%0d err=%b want v=1 id=2 data=445 err=0",
                rsp_valid, rsp_id, rsp_data, rsp_err); else passes++;
    tick();
    checks++; if ({rsp_valid, busy, job_count} !== {1'b0, 1'b0, 16'd1})
      $display("[TB] FAIL single_done: got v=%b busy=%b count=%0d want 0 0 1", rsp_valid, busy, job_count); else passes++;
  endtask

  task automatic test_round_robin();
    int g[5];
    int ng = 0;
    int cnt = 0;
    int not_onehot = 0;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 16'(i + 2), 16'd3, 16'd11);
    req_valid = 4'b1111;
    for (int cyc = 0; cyc < 200 && ng < 5; cyc++) begin
      eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_result = 16'h00A5;
        end
      end
      #1;
      if (req_ready !== 4'b0000) begin
        if (!$onehot(req_ready)) not_onehot++;
        for (int j = 0; j < N; j++) if (req_ready[j]) g[ng] = j;
        ng++;
      end
      if (eng_start) cnt = 3;
      tick();
    end
    eng_done = 1'b0;
    req_valid = '0;
    checks++; if (ng !== 5) $display("[TB] FAIL rr_grant_count: got %0d grants want 5", ng); else passes++;
    checks++; if (not_onehot !== 0) $display("[TB] FAIL rr_onehot: got %0d bad grants want 0", not_onehot); else passes++;
    checks++; if (ng == 5 && {g[0], g[1], g[2], g[3], g[4]} !== {32'd0, 32'd1, 32'd2, 32'd3, 32'd0})
      $display("[TB] FAIL rr_order: got %0d %0d %0d %0d %0d want 0 1 2 3 0", g[0], g[1], g[2], g[3], g[4]); else passes++;
  endtask

  task automatic test_zero_modulus();
    do_reset();
    rsp_ready = 1'b1;
    set_ops(1, 16'd5, 16'd3, 16'd0);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL zm_grant: got %b want 0010", req_ready); else passes++;
    tick();
    req_valid = '0;
    #1;
    checks++; if ({rsp_valid, eng_start, rsp_err, rsp_id, rsp_data} !== {1'b1, 1'b0, 1'b1, 2'd1, 16'd0})
      $display("[TB] FAIL zm_rsp: got v=%b start=%b err=%b id=%0d data=%0d want v=1 start=0 err=1 id=1 data=0",
                rsp_valid, eng_start, rsp_err, rsp_id, rsp_data); else passes++;
    tick();
    checks++; if ({rsp_valid, eng_start, job_count} !== {1'b0, 1'b0, 16'd1})
      $display("[TB] FAIL zm_done: got v=%b start=%b count=%0d want 0 0 1", rsp_valid, eng_start, job_count); else passes++;
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    rsp_ready = 1'b1;
    set_ops(0, 16'd7, 16'd9, 16'd33);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready_t !== 4'b0001) $display("[TB] FAIL to_grant: got %b want 0001", req_ready_t); else passes++;
    tick();
    req_valid = '0;
    #1;
    checks++; if (eng_start_t !== 1'b1) $display("[TB] FAIL to_start: got %b want 1", eng_start_t); else passes++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) early += int'(eng_abort_t) + int'(rsp_valid_t);
    end
    checks++; if (early !== 0) $display("[TB] FAIL to_early_abort: got %0d want 0", early); else passes++;
    checks++; if ({eng_abort_t, rsp_valid_t} !== 2'b10)
      $display("[TB] FAIL to_abort_8th: got abort=%b v=%b want 1 0", eng_abort_t, rsp_valid_t); else passes++;
    tick();
    checks++; if ({eng_abort_t, rsp_valid_t, rsp_err_t, rsp_id_t, rsp_data_t} !== {1'b0, 1'b1, 1'b1, 2'd0, 16'd0})
      $display("[TB] FAIL to_rsp: got abort=%b v=%b err=%b id=%0d data=%0d want 0 1 1 0 0",
                eng_abort_t, rsp_valid_t, rsp_err_t, rsp_id_t, rsp_data_t); else passes++;
    tick();
    checks++; if ({rsp_valid_t, job_count_t} !== {1'b0, 16'd1})
      $display("[TB] FAIL to_done: got v=%b count=%0d want 0 1", rsp_valid_t, job_count_t); else passes++;
    set_ops(3, 16'd2, 16'd5, 16'd7);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready_t !== 4'b1000) $display("[TB] FAIL to_next_grant: got %b want 1000", req_ready_t); else passes++;
    tick();
    req_valid = '0;
    #1;
    checks++; if ({eng_start_t, eng_modulus_t} !== {1'b1, 16'd7})
      $display("[TB] FAIL to_next_start: got start=%b mod=%0d want 1 7", eng_start_t, eng_modulus_t); else passes++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    rsp_ready = 1'b0;
    set_ops(1, 16'd3, 16'd4, 16'd5);
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    tick();
    eng_done = 1'b1; eng_result = 16'd1;
    #1;
    tick();
    eng_done = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd1, 16'd1, 1'b0})
      $display("[TB] FAIL bp_rsp: got v=%b id=%0d data=%0d err=%b want 1 1 1 0", rsp_valid, rsp_id, rsp_data, rsp_err); else passes++;
    for (int i = 0; i < 10; i++) begin
      tick();
      req_valid = 4'b1111;
      eng_done = (i == 4);
      eng_result = 16'hBEEF;
      #1;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, eng_start} !== {1'b1, 2'd1, 16'd1, 1'b0, 4'b0000, 1'b0})
        bad++;
    end
    checks++; if (bad !== 0) $display("[TB] FAIL bp_stable: got %0d unstable cycles want 0", bad); else passes++;
    eng_done = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_data, job_count} !== {1'b0, 16'd1, 16'd1})
      $display("[TB] FAIL bp_done: got v=%b data=%h count=%0d want 0 0001 1", rsp_valid, rsp_data, job_count); else passes++;
  endtask

  task automatic test_reset_mid_wait();
    rsp_ready = 1'b1;
    set_ops(2, 16'd6, 16'd7, 16'd9);
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy: got %b want 1", busy); else passes++;
    aresetn = 1'b0;
    tick();
    checks++; if ({eng_start, eng_abort, rsp_valid, rsp_err, busy, req_ready} !== 9'b0)
      $display("[TB] FAIL mid_reset_ctrl: got %b want 0", {eng_start, eng_abort, rsp_valid, rsp_err, busy, req_ready}); else passes++;
    checks++; if ({eng_number, eng_exponent, eng_modulus, rsp_data, rsp_id, job_count} !== 82'h0)
      $display("[TB] FAIL mid_reset_data: got %h want 0", {eng_number, eng_exponent, eng_modulus, rsp_data, rsp_id, job_count}); else passes++;
    aresetn = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL mid_regrant: got %b want 0001", req_ready); else passes++;
    tick();
    req_valid = '0;
    #1;
    checks++; if (eng_start !== 1'b1) $display("[TB] FAIL mid_restart: got %b want 1", eng_start); else passes++;
  endtask

  initial begin
    req_number = '0; req_exponent = '0; req_modulus = '0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_zero_modulus();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
